// File: rtl/vga_pkg.sv
// vga_pkg: timing presets, colour-bar palette and line/frame total helper for vga_timing_gen
package vga_pkg;

  typedef struct packed {
    int act;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  // 640x480@60, 25 MHz pixel clock
  localparam vga_axis_t VGA640_H = '{act: 640, fp: 16, sync: 96,  bp: 48};
  localparam vga_axis_t VGA640_V = '{act: 480, fp: 10, sync: 2,   bp: 33};
  // 800x600@72, 50 MHz pixel clock
  localparam vga_axis_t VGA800_H = '{act: 800, fp: 56, sync: 120, bp: 64};
  localparam vga_axis_t VGA800_V = '{act: 600, fp: 37, sync: 6,   bp: 23};

  // left-to-right colour bars: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_PALETTE = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int vga_total(input vga_axis_t a);
    return a.act + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH x DEPTH enabled shift register with async reset value; DEPTH=0 is a wire
module vga_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
    // shift one stage per enabled clock, hold otherwise
    always_comb begin
      sr_d[0] = en ? d : sr_q[0];
      for (int i = 1; i < DEPTH; i++) sr_d[i] = en ? sr_q[i-1] : sr_q[i];
    end
    // stage registers, reset to the inactive value
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= {DEPTH{RST_VAL}};
      else sr_q <= sr_d;
    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing with renderer-latency alignment (optional colour bars: VGA_PATTERN_EN)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT  = VGA640_H.act,
  parameter int H_FP   = VGA640_H.fp,
  parameter int H_SYNC = VGA640_H.sync,
  parameter int H_BP   = VGA640_H.bp,
  parameter int V_ACT  = VGA640_V.act,
  parameter int V_FP   = VGA640_V.fp,
  parameter int V_SYNC = VGA640_V.sync,
  parameter int V_BP   = VGA640_V.bp,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIPE   = 2,
  parameter int CW     = 11
) (
  input  logic          CLK_25,
  input  logic          RST_N,
  input  logic          EN,
  input  logic [23:0]   RGB_IN,
  input  logic          PATTERN_SEL,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          DE,
  output logic          FRAME_START,
  output logic [7:0]    FRAME_CNT,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);

  localparam int H_TOTAL = vga_total(vga_axis_t'{H_ACT, H_FP, H_SYNC, H_BP});
  localparam int V_TOTAL = vga_total(vga_axis_t'{V_ACT, V_FP, V_SYNC, V_BP});

  if (CW < $clog2(H_TOTAL) || CW < $clog2(V_TOTAL)) begin : g_cw_too_small
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (PIPE < 0 || PIPE > 15) begin : g_pipe_range
    $error("vga_timing_gen: PIPE must be 0..15");
  end

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACT + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic          de_q, de_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [23:0]   rgb_q, rgb_d, rgb_src;
  logic          vhs_q, vhs_d, vvs_q, vvs_d, blank_q, blank_d;
  logic          hs_dly, vs_dly, de_dly, h_wrap, v_wrap, frame_end;

  // HS/VS/DE wait PIPE clocks so they meet RGB_IN at the shared output register
  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_dly (
    .clk  (CLK_25),
    .rst_n(RST_N),
    .en   (EN),
    .d    ({hs_q, vs_q, de_q}),
    .q    ({hs_dly, vs_dly, de_dly})
  );

`ifdef VGA_PATTERN_EN
  logic [CW-1:0] bar_idx;
  logic [23:0]   bar_xy, bar_dly;
  vga_delay_line #(
    .WIDTH  (24),
    .DEPTH  (PIPE),
    .RST_VAL('0)
  ) u_bar_dly (
    .clk  (CLK_25),
    .rst_n(RST_N),
    .en   (EN),
    .d    (bar_xy),
    .q    (bar_dly)
  );
  // colour bar from the X/Y stage column, delayed like a renderer would be
  always_comb begin
    bar_idx = x_q / CW'(H_ACT / 8);
    bar_xy  = (bar_idx < CW'(8)) ? BAR_PALETTE[bar_idx[2:0]] : '0;
    rgb_src = PATTERN_SEL ? bar_dly : RGB_IN;
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = PATTERN_SEL;
  // renderer colour is the only pixel source
  always_comb rgb_src = RGB_IN;
`endif

  // counters, X/Y stage and output stage next-state; EN low holds everything
  always_comb begin
    h_wrap    = h_q == H_LAST;
    v_wrap    = v_q == V_LAST;
    frame_end = EN && x_q == H_LAST && y_q == V_LAST;
    h_d       = !EN ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d       = !(EN && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
    x_d       = EN ? h_q : x_q;
    y_d       = EN ? v_q : y_q;
    de_d      = EN ? (h_q < H_ACT_C && v_q < V_ACT_C) : de_q;
    fs_d      = EN ? (h_q == '0 && v_q == '0) : fs_q;
    hs_d      = EN ? ((h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL) : hs_q;
    vs_d      = EN ? ((v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL) : vs_q;
    fcnt_d    = fcnt_q + 8'(frame_end);
    rgb_d     = !EN ? rgb_q : de_dly ? rgb_src : '0;
    vhs_d     = EN ? hs_dly : vhs_q;
    vvs_d     = EN ? vs_dly : vvs_q;
    blank_d   = EN ? de_dly : blank_q;
  end

  // all state; syncs and blank reset to their inactive levels
  always_ff @(posedge CLK_25 or negedge RST_N)
    if (!RST_N) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fcnt_q  <= '0;
      rgb_q   <= '0;
      vhs_q   <= ~HS_POL;
      vvs_q   <= ~VS_POL;
      blank_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fcnt_q  <= fcnt_d;
      rgb_q   <= rgb_d;
      vhs_q   <= vhs_d;
      vvs_q   <= vvs_d;
      blank_q <= blank_d;
    end

  assign X           = x_q;
  assign Y           = y_q;
  assign DE          = de_q;
  assign FRAME_START = fs_q;
  assign FRAME_CNT   = fcnt_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = vhs_q;
  assign VGA_VS      = vvs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule
